// File: rtl/writeback_buffer.sv
// writeback_buffer: coalescing eviction FIFO with fill forwarding in front of backing memory
module writeback_buffer #(
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic [31:0]  c_addr_i,
    input  logic [127:0] c_wdata_i,
    input  logic         c_wren_i,
    input  logic         c_rden_i,
    output logic [127:0] c_rdata_o,
    output logic         c_rdata_valid_o,
    output logic         buf_full_o,
    output logic         overflow_o,
    output logic         rd_overrun_o,
    output logic [31:0]  m_addr_o,
    output logic [127:0] m_wdata_o,
    output logic         m_wren_o,
    output logic         m_rden_o,
    input  logic         m_ready_i,
    input  logic [127:0] m_rdata_i,
    input  logic         m_rdata_valid_i
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    typedef enum logic [1:0] {IDLE, FWD, RD_REQ, RD_WAIT} state_t;
    state_t        state_q, state_d;
    logic [27:0]   addr_q [DEPTH];
    logic [127:0]  data_q [DEPTH];
    logic [AW-1:0] head_q, head_d, tail_q, tail_d, match_idx, idx;
    logic [CW-1:0] count_q, count_d;
    logic [27:0]   lat_addr_q, lat_addr_d;
    logic [127:0]  c_rdata_q, c_rdata_d;
    logic          rvalid_q, rvalid_d, overflow_q, overflow_d, overrun_q, overrun_d;
    logic          match, rd_hit, rd_miss, coalesce, push, pop, drop, full;
    logic          unused_lsbs;

    assign unused_lsbs = ^c_addr_i[3:0];

    // Search valid entries oldest to youngest so the youngest match wins
    always_comb begin
        match = 1'b0;
        match_idx = '0;
        idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + AW'(i);
            if (CW'(i) < count_q && addr_q[idx] == c_addr_i[31:4]) begin
                match = 1'b1;
                match_idx = idx;
            end
        end
    end

    assign full     = count_q == CW'(DEPTH);
    assign rd_hit   = state_q == IDLE && c_rden_i && match;
    assign rd_miss  = state_q == IDLE && c_rden_i && !match;
    assign pop      = m_wren_o && m_ready_i;
    // A line leaving via the head this cycle cannot absorb new data, so it is queued afresh instead
    assign coalesce = c_wren_i && match && !(pop && match_idx == head_q);
    assign push     = c_wren_i && !coalesce && (!full || pop);
    assign drop     = c_wren_i && !coalesce && full && !pop;

    // Entry storage: push writes the tail, coalesce overwrites the matching line in place
    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_q[tail_q] <= c_addr_i[31:4];
            data_q[tail_q] <= c_wdata_i;
        end else if (coalesce) begin
            data_q[match_idx] <= c_wdata_i;
        end
    end

    // Datapath next state: pointers, occupancy, sticky flags, fill capture and response pulse
    always_comb begin
        head_d     = pop ? head_q + AW'(1) : head_q;
        tail_d     = push ? tail_q + AW'(1) : tail_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        lat_addr_d = rd_miss ? c_addr_i[31:4] : lat_addr_q;
        c_rdata_d  = rd_hit ? data_q[match_idx] :
                     (state_q == RD_WAIT && m_rdata_valid_i) ? m_rdata_i : c_rdata_q;
        rvalid_d   = rd_hit || (state_q == RD_WAIT && m_rdata_valid_i);
        overflow_d = overflow_q || drop;
        overrun_d  = overrun_q || (c_rden_i && state_q != IDLE);
    end

    // Datapath registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            lat_addr_q <= '0;
            c_rdata_q  <= '0;
            rvalid_q   <= 1'b0;
            overflow_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            lat_addr_q <= lat_addr_d;
            c_rdata_q  <= c_rdata_d;
            rvalid_q   <= rvalid_d;
            overflow_q <= overflow_d;
            overrun_q  <= overrun_d;
        end
    end

    // Fill FSM state register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= IDLE;
        else state_q <= state_d;
    end

    // Fill FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = rd_hit ? FWD : rd_miss ? RD_REQ : IDLE;
            FWD:     state_d = IDLE;
            RD_REQ:  state_d = m_ready_i ? RD_WAIT : RD_REQ;
            RD_WAIT: state_d = m_rdata_valid_i ? IDLE : RD_WAIT;
            default: state_d = IDLE;
        endcase
    end

    // Memory request outputs: fill read in RD_REQ, otherwise drain the head only when idle and unread
    always_comb begin
        m_rden_o  = state_q == RD_REQ;
        m_wren_o  = state_q == IDLE && !c_rden_i && count_q != '0;
        m_addr_o  = m_rden_o ? {lat_addr_q, 4'h0} : m_wren_o ? {addr_q[head_q], 4'h0} : '0;
        m_wdata_o = m_wren_o ? data_q[head_q] : '0;
    end

    assign c_rdata_o       = c_rdata_q;
    assign c_rdata_valid_o = rvalid_q;
    assign buf_full_o      = full;
    assign overflow_o      = overflow_q;
    assign rd_overrun_o    = overrun_q;
endmodule
